// File: rtl/ber_test_sequencer.sv
// Sequences one BER measurement over the I/Q counters: clear, phase search with
// timeout, windowed measurement, then a same-cycle snapshot of both channels plus verdict.
module ber_test_sequencer #(
  parameter int CLR_CYCLES = 4,
  parameter int TMO_W      = 32
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [63:0]      i_window_bits,
  input  logic [TMO_W-1:0] i_lock_timeout,
  input  logic [64:0]      i_err_limit,
  input  logic             i_phase_ok_i,
  input  logic             i_phase_ok_q,
  input  logic [63:0]      i_bits_i,
  input  logic [63:0]      i_errs_i,
  input  logic [63:0]      i_bits_q,
  input  logic [63:0]      i_errs_q,
  output logic             o_ber_reset,
  output logic             o_ber_enable,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_timeout,
  output logic             o_pass,
  output logic [63:0]      o_bits_i_lat,
  output logic [63:0]      o_errs_i_lat,
  output logic [63:0]      o_bits_q_lat,
  output logic [63:0]      o_errs_q_lat,
  output logic [64:0]      o_errs_tot,
  output logic [2:0]       o_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLR     = 3'd1,
    S_SEARCH  = 3'd2,
    S_MEASURE = 3'd3,
    S_LATCH   = 3'd4,
    S_DONE    = 3'd5,
    S_FAIL    = 3'd6
  } state_t;

  state_t           r_state, w_next;
  logic [7:0]       r_clr_cnt;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic [63:0]      r_window;
  logic [TMO_W-1:0] r_tmo_lim;
  logic [64:0]      r_err_lim;
  logic [63:0]      r_bits_i, r_errs_i, r_bits_q, r_errs_q;
  logic [64:0]      r_errs_tot;
  logic             r_pass;

  logic        w_start_ok, w_lock, w_win_met, w_sample;
  logic [64:0] w_sum;

  // Abort always beats a coincident start.
  assign w_start_ok = i_start && !i_abort;
  assign w_lock     = i_phase_ok_i && i_phase_ok_q;
  assign w_win_met  = (i_bits_i >= r_window) && (i_bits_q >= r_window);
  assign w_sum      = {1'b0, i_errs_i} + {1'b0, i_errs_q};
  assign w_sample   = (w_next == S_CLR) &&
                      (r_state == S_IDLE || r_state == S_DONE || r_state == S_FAIL);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_start_ok) w_next = S_CLR;
      S_CLR:
        if (i_abort)                             w_next = S_IDLE;
        else if (r_clr_cnt == 8'(CLR_CYCLES - 1)) w_next = S_SEARCH;
      S_SEARCH:
        if (i_abort)                     w_next = S_IDLE;
        else if (w_lock)                 w_next = S_MEASURE;
        else if (r_tmo_cnt == r_tmo_lim) w_next = S_FAIL;
      S_MEASURE:
        if (i_abort)        w_next = S_IDLE;
        else if (!w_lock)   w_next = S_FAIL;
        else if (w_win_met) w_next = S_LATCH;
      S_LATCH:   w_next = i_abort ? S_IDLE : S_DONE;
      S_DONE, S_FAIL:
        if (i_abort)         w_next = S_IDLE;
        else if (w_start_ok) w_next = S_CLR;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_clr_cnt  <= '0;
      r_tmo_cnt  <= '0;
      r_window   <= '0;
      r_tmo_lim  <= '0;
      r_err_lim  <= '0;
      r_bits_i   <= '0;
      r_errs_i   <= '0;
      r_bits_q   <= '0;
      r_errs_q   <= '0;
      r_errs_tot <= '0;
      r_pass     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_clr_cnt <= (r_state == S_CLR)    ? r_clr_cnt + 8'd1 : 8'd0;
      r_tmo_cnt <= (r_state == S_SEARCH) ? r_tmo_cnt + 1'b1 : '0;
      if (w_sample) begin
        r_window  <= i_window_bits;
        r_tmo_lim <= i_lock_timeout;
        r_err_lim <= i_err_limit;
      end
      // Single snapshot point so I and Q counts come from the same cycle.
      if (r_state == S_LATCH && !i_abort) begin
        r_bits_i   <= i_bits_i;
        r_errs_i   <= i_errs_i;
        r_bits_q   <= i_bits_q;
        r_errs_q   <= i_errs_q;
        r_errs_tot <= w_sum;
        r_pass     <= (w_sum <= r_err_lim);
      end
      if (w_next == S_FAIL) r_pass <= 1'b0;
    end
  end

  assign o_ber_reset  = (r_state == S_CLR);
  assign o_ber_enable = (r_state == S_SEARCH) || (r_state == S_MEASURE);
  assign o_busy       = (r_state == S_CLR) || (r_state == S_SEARCH) ||
                        (r_state == S_MEASURE) || (r_state == S_LATCH);
  assign o_done       = (r_state == S_DONE);
  assign o_timeout    = (r_state == S_FAIL);
  assign o_pass       = r_pass;
  assign o_bits_i_lat = r_bits_i;
  assign o_errs_i_lat = r_errs_i;
  assign o_bits_q_lat = r_bits_q;
  assign o_errs_q_lat = r_errs_q;
  assign o_errs_tot   = r_errs_tot;
  assign o_state      = r_state;

endmodule

// File: tb/tb_ber_test_sequencer.sv
// Directed bench for ber_test_sequencer: a small BER-counter model feeds the DUT,
// expected snapshots go into a scoreboard queue at start and are popped at DONE.
module tb_ber_test_sequencer;

  logic        clock, i_reset, i_start, i_abort;
  logic [63:0] i_window_bits;
  logic [31:0] i_lock_timeout;
  logic [64:0] i_err_limit;
  logic        i_phase_ok_i, i_phase_ok_q;
  logic [63:0] i_bits_i, i_errs_i, i_bits_q, i_errs_q;
  logic        o_ber_reset, o_ber_enable, o_busy, o_done, o_timeout, o_pass;
  logic [63:0] o_bits_i_lat, o_errs_i_lat, o_bits_q_lat, o_errs_q_lat;
  logic [64:0] o_errs_tot;
  logic [2:0]  o_state;

  ber_test_sequencer #(.CLR_CYCLES(4), .TMO_W(32)) dut (
    .clock(clock), .i_reset(i_reset), .i_start(i_start), .i_abort(i_abort),
    .i_window_bits(i_window_bits), .i_lock_timeout(i_lock_timeout), .i_err_limit(i_err_limit),
    .i_phase_ok_i(i_phase_ok_i), .i_phase_ok_q(i_phase_ok_q),
    .i_bits_i(i_bits_i), .i_errs_i(i_errs_i), .i_bits_q(i_bits_q), .i_errs_q(i_errs_q),
    .o_ber_reset(o_ber_reset), .o_ber_enable(o_ber_enable), .o_busy(o_busy), .o_done(o_done),
    .o_timeout(o_timeout), .o_pass(o_pass),
    .o_bits_i_lat(o_bits_i_lat), .o_errs_i_lat(o_errs_i_lat),
    .o_bits_q_lat(o_bits_q_lat), .o_errs_q_lat(o_errs_q_lat),
    .o_errs_tot(o_errs_tot), .o_state(o_state)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [63:0] ei;
    logic [63:0] eq;
    logic [64:0] tot;
    logic        pass;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  // BER-counter model state
  logic [63:0] m_bits;
  int          en_cnt;
  int          lock_at_i, lock_at_q;
  bit          drop_i, mode_max;
  logic [63:0] cfg_ei, cfg_eq;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic update_model();
    if (mode_max) begin
      m_bits = 64'hFFFF_FFFF_FFFF_FFFF;
    end else if (o_ber_reset) begin
      m_bits = '0;
      en_cnt = 0;
    end else if (o_ber_enable) begin
      en_cnt++;
      m_bits = m_bits + 64'd100;
    end
    i_bits_i     = m_bits;
    i_bits_q     = m_bits;
    i_errs_i     = cfg_ei;
    i_errs_q     = cfg_eq;
    i_phase_ok_i = (en_cnt >= lock_at_i) && !drop_i;
    i_phase_ok_q = (en_cnt >= lock_at_q);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    update_model();
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int max, input string tag);
    int n = 0;
    while (o_state !== s && n < max) begin
      tick();
      n++;
    end
    check(tag, 65'(o_state), 65'(s));
  endtask

  task automatic push_exp(input logic [63:0] ei, input logic [63:0] eq, input logic [64:0] lim);
    exp_t e;
    e.ei   = ei;
    e.eq   = eq;
    e.tot  = {1'b0, ei} + {1'b0, eq};
    e.pass = (e.tot <= lim);
    sb.push_back(e);
  endtask

  task automatic check_done(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 65'd0, 65'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_errs_i"}, 65'(o_errs_i_lat), 65'(e.ei));
      check({tag, "_errs_q"}, 65'(o_errs_q_lat), 65'(e.eq));
      check({tag, "_tot"},    o_errs_tot,        e.tot);
      check({tag, "_pass"},   65'(o_pass),       65'(e.pass));
      check({tag, "_done"},   65'(o_done),       65'd1);
      check({tag, "_enable"}, 65'(o_ber_enable), 65'd0);
    end
  endtask

  initial begin
    int n;
    i_reset = 1'b1; i_start = 1'b0; i_abort = 1'b0;
    i_window_bits = 64'd1000; i_lock_timeout = 32'd1000; i_err_limit = 65'd5;
    m_bits = '0; en_cnt = 0; lock_at_i = 20; lock_at_q = 20;
    drop_i = 1'b0; mode_max = 1'b0; cfg_ei = 64'd2; cfg_eq = 64'd3;
    update_model();
    repeat (3) tick();
    check("rst_state",  65'(o_state),      65'd0);
    check("rst_reset",  65'(o_ber_reset),  65'd0);
    check("rst_enable", 65'(o_ber_enable), 65'd0);
    check("rst_pass",   65'(o_pass),       65'd0);
    check("rst_tot",    o_errs_tot,        65'd0);
    check("rst_busy",   65'(o_busy),       65'd0);
    i_reset = 1'b0;
    tick();

    // Nominal run: errs 2+3 against limit 5
    push_exp(64'd2, 64'd3, 65'd5);
    pulse_start();
    n = 0;
    for (int k = 0; k < 20 && o_state !== 3'd2; k++) begin
      if (o_ber_reset) n++;
      tick();
    end
    check("nom_clr_cycles", 65'(n), 65'd4);
    check("nom_tmo_zero_enable", 65'(o_ber_enable), 65'd1);
    wait_state(3'd5, 200, "nom_reach_done");
    check_done("nom");
    check("nom_bits_ge_window", 65'(o_bits_i_lat >= 64'd1000), 65'd1);

    // Fail verdict: errs 2+4 against limit 5; config change mid-run ignored
    cfg_eq = 64'd4;
    update_model();
    push_exp(64'd2, 64'd4, 65'd5);
    pulse_start();
    i_err_limit = 65'd100;
    wait_state(3'd5, 200, "fv_reach_done");
    check_done("fv");
    i_err_limit = 65'd5;

    // Lock timeout: Q never locks, limit 50
    i_lock_timeout = 32'd50;
    lock_at_q = 32'h7FFF_FFFF;
    pulse_start();
    wait_state(3'd2, 20, "tmo_reach_search");
    n = 0;
    while (o_state !== 3'd6 && n < 200) begin
      tick();
      n++;
    end
    check("tmo_cycles",  65'(n),            65'd51);
    check("tmo_flag",    65'(o_timeout),    65'd1);
    check("tmo_enable",  65'(o_ber_enable), 65'd0);
    check("tmo_pass",    65'(o_pass),       65'd0);
    check("tmo_keep_ei", 65'(o_errs_i_lat), 65'd2);
    check("tmo_keep_tot", o_errs_tot,       65'd6);

    // Lock loss mid-measure
    i_lock_timeout = 32'd1000;
    lock_at_q = 20;
    i_window_bits = 64'd1_000_000;
    pulse_start();
    wait_state(3'd3, 100, "loss_reach_measure");
    tick(); tick();
    drop_i = 1'b1;
    i_phase_ok_i = 1'b0;
    tick();
    check("loss_state", 65'(o_state), 65'd6);
    check("loss_pass",  65'(o_pass),  65'd0);
    drop_i = 1'b0;
    update_model();

    // Abort + start together in MEASURE: abort wins
    pulse_start();
    wait_state(3'd3, 100, "race_reach_measure");
    i_abort = 1'b1; i_start = 1'b1;
    tick();
    i_abort = 1'b0; i_start = 1'b0;
    check("race_state",  65'(o_state),      65'd0);
    check("race_enable", 65'(o_ber_enable), 65'd0);
    check("race_reset",  65'(o_ber_reset),  65'd0);
    check("race_keep",   65'(o_errs_q_lat), 65'd4);
    // Start in SEARCH ignored
    pulse_start();
    wait_state(3'd2, 20, "ign_reach_search");
    pulse_start();
    check("ign_state", 65'(o_state), 65'd2);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check("abort_search", 65'(o_state), 65'd0);

    // Window 0, locks already high; total exactly at limit passes
    lock_at_i = 0; lock_at_q = 0;
    i_window_bits = 64'd0;
    i_err_limit = 65'd8;
    cfg_ei = 64'd7; cfg_eq = 64'd1;
    update_model();
    push_exp(64'd7, 64'd1, 65'd8);
    pulse_start();
    wait_state(3'd3, 20, "w0_reach_measure");
    tick();
    check("w0_latch_next", 65'(o_state), 65'd4);
    tick();
    check_done("w0");

    // Near-max counts: carry into bit 64
    mode_max = 1'b1;
    cfg_ei = 64'hFFFF_FFFF_FFFF_FFFF;
    cfg_eq = 64'hFFFF_FFFF_FFFF_FFFE;
    i_window_bits = 64'd5;
    i_err_limit = 65'd0;
    update_model();
    push_exp(cfg_ei, cfg_eq, 65'd0);
    pulse_start();
    wait_state(3'd5, 100, "max_reach_done");
    check_done("max");
    check("max_carry", 65'(o_errs_tot[64]), 65'd1);

    // Abort from DONE
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check("done_abort", 65'(o_state), 65'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
